// File: rtl/cpu_pkg.sv
// Shared CPU constants: ARM condition codes, NZCV bit positions and FlagW fields.
// Imported by the conditional-execution logic and its condition checker.
package cpu_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

endpackage

// File: rtl/condlogic_if.sv
// Decoder-to-condlogic bundle: write requests and ALU flags in, gated write enables out.
// The master side is the decoder/FSM; the slave side is the conditional-execution unit.
interface condlogic_if;

   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       NextPC;
   logic       RegW;
   logic       MemW;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic [3:0] Flags;

   modport master (
      output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
      input  PCWrite, RegWrite, MemWrite, Flags
   );

   modport slave (
      input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
      output PCWrite, RegWrite, MemWrite, Flags
   );

endinterface

// File: rtl/condlogic_condcheck.sv
// Purely combinational ARM condition evaluator: Cond field against NZCV flags.
// Kept separate so a future pipelined datapath can reuse it directly.
module condcheck
   import cpu_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   // NV is architecturally unpredictable, so it falls into the default and never executes
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = c & ~z;
         COND_LS: CondEx = ~c | z;
         COND_GE: CondEx = ~(n ^ v);
         COND_LT: CondEx = n ^ v;
         COND_GT: CondEx = ~z & ~(n ^ v);
         COND_LE: CondEx = z | (n ^ v);
         COND_AL: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution unit: NZCV register, condition check and write-enable gating.
// The condition result is delayed one cycle so Decode's verdict governs Execute/Writeback writes.
module condlogic
   import cpu_pkg::*;
#(
   parameter logic [3:0] FLAGS_RESET = 4'b0000
)(
   input logic       clk,
   input logic       reset,
   condlogic_if.slave bus
);

   logic [3:0] flagsR;
   logic       condEx;
   logic       condExR;
   logic       flagWrNz;
   logic       flagWrCv;

   condcheck uCondcheck (
      .Cond   (bus.Cond),
      .Flags  (flagsR),
      .CondEx (condEx)
   );

   assign flagWrNz = bus.FlagW[FLAGW_NZ] & condEx;
   assign flagWrCv = bus.FlagW[FLAGW_CV] & condEx;

   // NZ and CV are separately enabled; a squashed instruction leaves both untouched
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flagsR  <= FLAGS_RESET;
         condExR <= 1'b0;
      end else begin
         if (flagWrNz) flagsR[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
         if (flagWrCv) flagsR[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
         condExR <= condEx;
      end
   end

   // Fetch increments bypass the condition so the PC always advances
   assign bus.PCWrite  = (bus.PCS & condExR) | bus.NextPC;
   assign bus.RegWrite = bus.RegW & condExR;
   assign bus.MemWrite = bus.MemW & condExR;
   assign bus.Flags    = flagsR;

endmodule

// File: tb/tb_condlogic.sv
// Self-checking bench for condlogic: directed scenarios, exhaustive condition sweep
// and random traffic, all compared against an ARM-rules reference model.
module tb_condlogic;

   localparam logic [3:0] TB_FLAGS_RESET = 4'b0000;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;

   logic [3:0] mFlags;
   logic       mCondExR;

   condlogic_if bus ();

   condlogic #(.FLAGS_RESET(TB_FLAGS_RESET)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: base test from Cond[3:1], Cond[0] inverts it, AL always true, NV never
   function automatic logic refCond(input logic [3:0] cond, input logic [3:0] f);
      bit n, z, c, v, base;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (cond == 4'b1111) return 1'b0;
      return cond[0] ? !base : base;
   endfunction

   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, observed, expected, $time);
      end
   endtask

   // One cycle: drive just after the edge, check mid-cycle, then advance the model at the edge
   task automatic applyStimulus(input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] flagW,
                                input logic pcs, input logic nextPc, input logic regW, input logic memW);
      logic ce;
      bus.Cond = cond; bus.ALUFlags = alu; bus.FlagW = flagW;
      bus.PCS = pcs; bus.NextPC = nextPc; bus.RegW = regW; bus.MemW = memW;
      @(negedge clk);
      checkOutput("Flags", bus.Flags, mFlags);
      checkOutput("PCWrite", {3'b0, bus.PCWrite}, {3'b0, (pcs & mCondExR) | nextPc});
      checkOutput("RegWrite", {3'b0, bus.RegWrite}, {3'b0, regW & mCondExR});
      checkOutput("MemWrite", {3'b0, bus.MemWrite}, {3'b0, memW & mCondExR});
      @(posedge clk);
      if (reset) begin
         ce = refCond(cond, mFlags);
         if (ce && flagW[1]) mFlags[3:2] = alu[3:2];
         if (ce && flagW[0]) mFlags[1:0] = alu[1:0];
         mCondExR = ce;
      end
      #1;
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      mFlags = TB_FLAGS_RESET;
      mCondExR = 1'b0;
      reset = 1'b0;
      bus.Cond = 4'b1110; bus.ALUFlags = 4'b0; bus.FlagW = 2'b0;
      bus.PCS = 1'b0; bus.NextPC = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;

      // Reset held with all requests up: nothing may be written
      applyStimulus(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
      reset = 1'b1;
      applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);

      // Flag set then use, EQ then NE
      applyStimulus(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Partial flag writes
      applyStimulus(4'b1110, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b1110, 4'b0111, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Squash: clear flags, then EQ fails so flags hold and writes are gated; NextPC still wins
      applyStimulus(4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);

      // Every Cond against every flag value
      for (int f = 0; f < 16; f++) begin
         applyStimulus(4'b1110, 4'(f), 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
         for (int c = 0; c < 16; c++)
            applyStimulus(4'(c), 4'(15 - f), 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
         applyStimulus(4'b1111, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
      end

      // Asynchronous reset between edges with a pending write
      applyStimulus(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.RegW = 1'b1;
      checkOutput("preResetRegWrite", {3'b0, bus.RegWrite}, 4'b0001);
      #1 reset = 1'b0;
      #1;
      mFlags = TB_FLAGS_RESET;
      mCondExR = 1'b0;
      checkOutput("asyncFlags", bus.Flags, TB_FLAGS_RESET);
      checkOutput("asyncRegWrite", {3'b0, bus.RegWrite}, 4'b0000);
      applyStimulus(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
      reset = 1'b1;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/condlogic.md
Name: condlogic

Overview:
- Conditional-execution unit for the multi-cycle ARM datapath; the consumer of the decoder's control outputs.
- Holds the NZCV flag register and evaluates the instruction's Cond field against the current flags.
- Delays the condition result by one cycle and gates the decoder's write requests into the architectural write enables for the PC, register file and memory.
- Sits between the decoder/main FSM and the datapath write ports.

Parameters:
FLAGS_RESET, 4'b0000, NZCV value loaded into the flag register on reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
Cond  input  4  instruction condition field, Instr[31:28].
ALUFlags  input  4  ALU flag result, ordered {N,Z,C,V}.
FlagW  input  2  flag write request from the decoder: [1] updates N,Z; [0] updates C,V.
PCS  input  1  PC-write request from the decoder (branch, or Rd==R15 with RegW).
NextPC  input  1  unconditional PC update from the FSM (fetch increment).
RegW  input  1  register-file write request.
MemW  input  1  memory write request.
PCWrite  output  1  PC register enable.
RegWrite  output  1  register-file write enable.
MemWrite  output  1  data-memory write enable.
Flags  output  4  current registered NZCV, for debug and observability.

Behaviour:
- State held: Flags[3:0] (two independently enabled fields, NZ = Flags[3:2] and CV = Flags[1:0]) and a 1-bit CondExR.
- Reset (reset==0, asynchronous):
  - Flags = FLAGS_RESET and CondExR = 0 immediately, independent of clk.
  - Outputs while in reset: RegWrite=0, MemWrite=0, PCWrite=NextPC.
- CondEx is combinational from Cond and the registered Flags (pre-update values), per the ARM table:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1.
  - 1111 (unpredictable) gives CondEx = 0.
- Flag write:
  - On the rising edge, NZ <= ALUFlags[3:2] if FlagW[1]&CondEx; CV <= ALUFlags[1:0] if FlagW[0]&CondEx.
  - Fields not enabled hold their value.
- CondExR <= CondEx every rising edge: one-cycle delay so the result computed in Decode governs writes in Execute/Writeback.
- Outputs (combinational, no further latency):
  - PCWrite = (PCS & CondExR) | NextPC
  - RegWrite = RegW & CondExR
  - MemWrite = MemW & CondExR
- Simultaneous flag write and condition evaluation in the same cycle: CondEx uses the old flags. New flags are visible to CondEx in the next cycle.
- NextPC always wins: fetch increments are never squashed, even when CondExR=0.
- Reset deasserted mid-instruction: CondExR=0 squashes any pending conditional write for the first cycle after release.
- Flags holds its value indefinitely when FlagW=00. No other state exists.

Decomposition:
- Shared package (cpu_pkg):
  - Condition-code constants COND_EQ..COND_AL, COND_NV.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW field indices FLAGW_NZ=1, FLAGW_CV=0.
- Sub-module condcheck (purely combinational): Cond, Flags -> CondEx. Reused by any future pipelined variant.
- condlogic holds the registers and gating.

Test Plan:
- Reset: hold reset=0 with RegW=MemW=PCS=1, NextPC=0 -> Flags=0000, RegWrite=MemWrite=PCWrite=0. Release with Cond=1110 -> all three assert from the next edge.
- Flag set then use:
  - Cycle 1: Cond=1110, FlagW=11, ALUFlags=0100 -> Flags=0100 after the edge.
  - Cycle 2: Cond=0000, RegW=1 -> RegWrite=1 in cycle 3.
  - Repeat with Cond=0001 -> RegWrite=0.
- Partial write: Flags=0100, Cond=1110, FlagW=10, ALUFlags=1011 -> Flags=1000. Then FlagW=01, ALUFlags=0111 -> Flags=1011.
- Squash: Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, PCS=1, MemW=1 -> Flags stays 0000; next cycle PCWrite=0, MemWrite=0. Add NextPC=1 -> PCWrite=1.
- Exhaustive condcheck: all 16 Cond x 16 Flags against the table model; Cond=1111 always gives 0.
- Async reset mid-op: Flags=1111, CondExR=1, RegW=1; drive reset=0 between edges -> Flags=FLAGS_RESET and RegWrite=0 before the next clk edge.
